video_timing_gen: RTL

- Synthetic video source driving the RGB + dv/hs/vs stream the sobel pipeline consumes.
- Used as the bench and bring-up stimulus in place of the HDMI receiver.
- Generates raster timing from programmable porch/sync parameters and fills the active area with one of four test patterns.
- Sync polarity matches the downstream POL_HS/POL_VS convention.

---
 rtl/video_timing_gen.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/video_timing_gen.sv
// Synthetic raster source: programmable h/v timing with four selectable test patterns.
// All outputs are registered one clock after the counter state they describe.
module video_timing_gen #(
  parameter int unsigned COLORDEPTH = 8,
  parameter int unsigned H_ACTIVE   = 1600,
  parameter int unsigned H_FP       = 24,
  parameter int unsigned H_SYNC     = 72,
  parameter int unsigned H_BP       = 96,
  parameter int unsigned V_ACTIVE   = 900,
  parameter int unsigned V_FP       = 1,
  parameter int unsigned V_SYNC     = 3,
  parameter int unsigned V_BP       = 96,
  parameter int unsigned POL_HS     = 1,
  parameter int unsigned POL_VS     = 1,
  parameter int unsigned CHK_LOG2   = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [1:0]            pattern_i,
  output logic [COLORDEPTH-1:0] red_o,
  output logic [COLORDEPTH-1:0] green_o,
  output logic [COLORDEPTH-1:0] blue_o,
  output logic                  dv_o,
  output logic                  hs_o,
  output logic                  vs_o,
  output logic                  frame_start_o
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned PW      = HW + 5;
  localparam int unsigned BAR_W   = H_ACTIVE / 8;
  localparam int unsigned SW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam logic        HS_IDLE = (POL_HS != 0) ? 1'b0 : 1'b1;
  localparam logic        VS_IDLE = (POL_VS != 0) ? 1'b0 : 1'b1;
  localparam logic [COLORDEPTH-1:0] MAX = '1;

  logic [HW-1:0]         h_cnt;
  logic [VW-1:0]         v_cnt;
  logic [HW-1:0]         pos;
  logic [1:0]            pattern_q;
  logic [SW-1:0]         seg_cnt;
  logic [2:0]            bar_idx;

  logic                  h_last, v_last, frame_first;
  logic                  dv_c, hs_c, vs_c, bar_on;
  logic [1:0]            pat_c;
  logic [PW-1:0]         h_ext, pos_ext, pos_p4;
  logic [HW-1:0]         pos_nxt;
  logic [COLORDEPTH-1:0] r_c, g_c, b_c;

  // Raster decode and pixel generation for the current counter position
  always_comb begin
    r_c         = '0;
    g_c         = '0;
    b_c         = '0;
    h_last      = (h_cnt == HW'(H_TOTAL - 1));
    v_last      = (v_cnt == VW'(V_TOTAL - 1));
    frame_first = (h_cnt == '0) && (v_cnt == '0);
    dv_c        = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
    hs_c        = (h_cnt >= HW'(H_ACTIVE + H_FP)) && (h_cnt <= HW'(H_ACTIVE + H_FP + H_SYNC - 1));
    vs_c        = (v_cnt >= VW'(V_ACTIVE + V_FP)) && (v_cnt <= VW'(V_ACTIVE + V_FP + V_SYNC - 1));
    // The pattern sampled at frame start already applies to pixel (0,0)
    pat_c       = frame_first ? pattern_i : pattern_q;
    h_ext       = PW'(h_cnt);
    pos_ext     = PW'(pos);
    pos_p4      = pos_ext + PW'(4);
    pos_nxt     = (pos_p4 >= PW'(H_ACTIVE)) ? '0 : HW'(pos_p4);
    bar_on      = (h_ext >= pos_ext) && (h_ext < pos_ext + PW'(16));
    if (dv_c) begin
      case (pat_c)
        2'd0: begin
          r_c = bar_idx[1] ? '0 : MAX;
          g_c = bar_idx[2] ? '0 : MAX;
          b_c = bar_idx[0] ? '0 : MAX;
        end
        2'd1: begin
          r_c = COLORDEPTH'(h_cnt);
          g_c = COLORDEPTH'(h_cnt);
          b_c = COLORDEPTH'(h_cnt);
        end
        2'd2: begin
          if (h_cnt[CHK_LOG2] ^ v_cnt[CHK_LOG2]) begin
            r_c = MAX;
            g_c = MAX;
            b_c = MAX;
          end
        end
        default: begin
          if (bar_on) begin
            r_c = MAX;
            g_c = MAX;
            b_c = MAX;
          end
        end
      endcase
    end
  end

  // Counters, frame state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt         <= '0;
      v_cnt         <= '0;
      pos           <= '0;
      pattern_q     <= 2'd0;
      seg_cnt       <= '0;
      bar_idx       <= 3'd0;
      red_o         <= '0;
      green_o       <= '0;
      blue_o        <= '0;
      dv_o          <= 1'b0;
      hs_o          <= HS_IDLE;
      vs_o          <= VS_IDLE;
      frame_start_o <= 1'b0;
    end else if (en) begin
      red_o         <= r_c;
      green_o       <= g_c;
      blue_o        <= b_c;
      dv_o          <= dv_c;
      hs_o          <= hs_c ^ HS_IDLE;
      vs_o          <= vs_c ^ VS_IDLE;
      frame_start_o <= frame_first;
      if (frame_first) pattern_q <= pattern_i;
      if (h_last) begin
        h_cnt   <= '0;
        seg_cnt <= '0;
        bar_idx <= 3'd0;
        if (v_last) begin
          v_cnt <= '0;
          pos   <= pos_nxt;
        end else begin
          v_cnt <= v_cnt + VW'(1);
        end
      end else begin
        h_cnt <= h_cnt + HW'(1);
        // Bar index advances on a segment counter instead of dividing h_cnt
        if (seg_cnt == SW'(BAR_W - 1)) begin
          seg_cnt <= '0;
          bar_idx <= bar_idx + 3'd1;
        end else begin
          seg_cnt <= seg_cnt + SW'(1);
        end
      end
    end else begin
      red_o         <= '0;
      green_o       <= '0;
      blue_o        <= '0;
      dv_o          <= 1'b0;
      hs_o          <= HS_IDLE;
      vs_o          <= VS_IDLE;
      frame_start_o <= 1'b0;
    end
  end

endmodule
